// File: rtl/es_div_sequencer.sv
// rtl/es_div_sequencer.sv - iterative radix-2 restoring DIV/DIVU sequencer for the execute stage
module es_div_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_cancel,
  input  logic        ms_allowin,
  output logic        div_ready_go,
  output logic        div_busy,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  // Partial remainder magnitude; it always stays below the divisor, so the
  // 33-bit quantity only exists transiently as the shifted/trial values.
  logic [31:0] rem;
  logic [31:0] dq;
  logic [31:0] dvsr;
  logic [31:0] src1_q;
  logic        q_neg;
  logic        r_neg;
  logic        zero;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] abs1;
  logic [31:0] abs2;

  // Restoring step: shift in the next dividend bit and try subtracting |divisor|
  assign shifted = {1'b0, rem, dq[31]};
  assign trial   = shifted - {1'b0, dvsr};

  // Operand magnitudes, only taken for signed divides
  assign abs1 = (div_signed && div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
  assign abs2 = (div_signed && div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;

  // Stage handshake: hold the stage while a divide is pending or computing
  assign div_ready_go = (state == DONE) || ((state == IDLE) && !div_valid);
  assign div_busy     = (state != IDLE);

  // Sequencer FSM and datapath; cancel wins over capture and DONE exit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= 6'd0;
      rem           <= 32'd0;
      dq            <= 32'd0;
      dvsr          <= 32'd0;
      src1_q        <= 32'd0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      zero          <= 1'b0;
      div_quotient  <= 32'd0;
      div_remainder <= 32'd0;
      div_by_zero   <= 1'b0;
    end else if (div_cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            dq     <= abs1;
            dvsr   <= abs2;
            src1_q <= div_src1;
            q_neg  <= div_signed & (div_src1[31] ^ div_src2[31]);
            r_neg  <= div_signed & div_src1[31];
            zero   <= (div_src2 == 32'd0);
            rem    <= 32'd0;
            cnt    <= 6'd0;
            state  <= ITER;
          end
        end
        ITER: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            dq  <= {dq[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            dq  <= {dq[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            div_quotient  <= 32'hFFFF_FFFF;
            div_remainder <= src1_q;
            div_by_zero   <= 1'b1;
          end else begin
            div_quotient  <= q_neg ? (~dq + 32'd1) : dq;
            div_remainder <= r_neg ? (~rem + 32'd1) : rem;
            div_by_zero   <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          if (ms_allowin) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_es_div_sequencer.sv
// tb/tb_es_div_sequencer.sv - directed bench for es_div_sequencer
module tb_es_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        ms_allowin;
  logic        div_ready_go;
  logic        div_busy;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] held_q;

  es_div_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_valid     (div_valid),
    .div_signed    (div_signed),
    .div_src1      (div_src1),
    .div_src2      (div_src2),
    .div_cancel    (div_cancel),
    .ms_allowin    (ms_allowin),
    .div_ready_go  (div_ready_go),
    .div_busy      (div_busy),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  // div_valid must stay high while the sequencer is computing
  always @(negedge clk) begin
    if (resetn && div_busy && !div_ready_go && !div_cancel) begin
      assert (div_valid === 1'b1) else begin
        errors++;
        $error("FAIL valid_drop observed=%b expected=1", div_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    div_valid  = 1'b1;
    #1;
    chk("rg_low_at_issue", {31'd0, div_ready_go}, 32'd0);
  endtask

  // Counts edges from capture until ready_go; scrambles operands after capture
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        div_src1   = 32'hDEAD_BEEF;
        div_src2   = 32'd0;
        div_signed = ~div_signed;
        chk("busy_in_iter", {31'd0, div_busy}, 32'd1);
      end
    end while (!div_ready_go && n < 100);
  endtask

  task automatic release_div();
    tick();
    div_valid = 1'b0;
    #1;
    chk("busy_after_done", {31'd0, div_busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic bz);
    int n;
    start_div(sgn, a, b);
    wait_done(n);
    chk({tag, "_latency"}, n, 32'd34);
    chk({tag, "_q"}, div_quotient, q);
    chk({tag, "_r"}, div_remainder, r);
    chk({tag, "_bz"}, {31'd0, div_by_zero}, {31'd0, bz});
    release_div();
  endtask

  initial begin
    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_cancel = 1'b0;
    ms_allowin = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("reset_rg", {31'd0, div_ready_go}, 32'd1);
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_q", div_quotient, 32'd0);
    chk("reset_r", div_remainder, 32'd0);
    chk("reset_bz", {31'd0, div_by_zero}, 32'd0);

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Backpressure: DONE held while memory stage refuses
    ms_allowin = 1'b0;
    start_div(1'b0, 32'd1000, 32'd7);
    wait_done(lat);
    chk("bp_latency", lat, 32'd34);
    chk("bp_q", div_quotient, 32'd142);
    chk("bp_r", div_remainder, 32'd6);
    held_q = div_quotient;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_rg", {31'd0, div_ready_go}, 32'd1);
      chk("bp_hold_busy", {31'd0, div_busy}, 32'd1);
      chk("bp_hold_q", div_quotient, held_q);
      chk("bp_hold_r", div_remainder, 32'd6);
    end
    ms_allowin = 1'b1;
    release_div();

    // Cancel at iteration counter 10, then immediate follow-up divide
    start_div(1'b0, 32'd50, 32'd3);
    repeat (11) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    chk("cancel_busy", {31'd0, div_busy}, 32'd0);
    run("divu_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

    // Asynchronous reset in the middle of ITER
    start_div(1'b0, 32'd77, 32'd5);
    repeat (5) tick();
    #2;
    resetn    = 1'b0;
    div_valid = 1'b0;
    #1;
    chk("areset_busy", {31'd0, div_busy}, 32'd0);
    chk("areset_rg", {31'd0, div_ready_go}, 32'd1);
    chk("areset_q", div_quotient, 32'd0);
    chk("areset_r", div_remainder, 32'd0);
    chk("areset_bz", {31'd0, div_by_zero}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run("divu_1_1", 1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/es_div_sequencer.md
# es_div_sequencer

Multi-cycle divide sequencer for the execute stage. It runs MIPS DIV/DIVU on an iterative radix-2 restoring datapath, one quotient bit per cycle. It holds the execute stage through its ready-go input until the quotient and remainder are ready, then releases the result when the memory stage accepts it. It sits beside the single-cycle ALU in the execute stage; its ready-go output is ANDed into the stage's ready-go.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- div_valid  in  1  execute stage holds a valid DIV/DIVU (es_valid && div op)
- div_signed  in  1  1 = DIV (signed), 0 = DIVU
- div_src1  in  32  dividend (rs value)
- div_src2  in  32  divisor (rt value)
- div_cancel  in  1  flush of the execute-stage instruction; aborts any operation
- ms_allowin  in  1  memory stage accepts the execute-stage instruction this cycle
- div_ready_go  out  1  execute-stage ready-go contribution
- div_busy  out  1  an operation is in flight (not IDLE)
- div_quotient  out  32  quotient, valid while in DONE
- div_remainder  out  32  remainder, valid while in DONE
- div_by_zero  out  1  divisor was zero, valid while in DONE

## Operation
- States: IDLE, ITER, FIX, DONE. Internal registers:
  - 6-bit iteration counter
  - 33-bit partial remainder
  - 32-bit dividend/quotient shift register
  - 32-bit |divisor|
  - sign flags q_neg and r_neg
  - zero flag
- IDLE:
  - When div_valid=1 and div_cancel=0, capture operands and go to ITER with counter=0.
  - Captured dividend and divisor are absolute values when div_signed=1 (two's complement negate if bit31=1); otherwise they are captured unchanged.
  - q_neg = div_signed & (src1[31]^src2[31]).
  - r_neg = div_signed & src1[31].
  - zero = (src2 == 0).
- ITER, each cycle:
  - Form trial = {rem[31:0], dq[31]} − {1'b0, divisor}, 33-bit.
  - If trial is non-negative: rem ← trial and the new quotient bit is 1. Otherwise rem ← {rem[31:0], dq[31]} and the bit is 0.
  - dq ← {dq[30:0], bit}; counter +1.
  - After counter reaches 31, go to FIX.
- FIX, one cycle:
  - Quotient = q_neg ? −dq : dq.
  - Remainder = r_neg ? −rem[31:0] : rem[31:0].
  - If zero=1, override: quotient = 32'hFFFF_FFFF, remainder = original src1 (kept in a separate register), div_by_zero=1.
  - Go to DONE.
- DONE: hold the results. If ms_allowin=1, go to IDLE next cycle and keep the outputs until the next capture.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF is handled by the natural datapath: quotient 0x8000_0000, remainder 0. No trap.
- div_ready_go:
  - 1 in IDLE with div_valid=0.
  - 0 in IDLE with div_valid=1, in ITER, and in FIX.
  - 1 in DONE.
- div_cancel=1 in any state goes to IDLE next cycle with no result. Cancel has priority over capture and over DONE exit.

## Timing
- Reset (asynchronous assert, release synchronous to clk): state IDLE, div_ready_go=1 (with div_valid=0), div_busy=0, div_quotient=0, div_remainder=0, div_by_zero=0, counter=0.
- Capture at edge T, where div_valid=1 in IDLE at cycle T.
  - ITER occupies cycles T+1..T+32.
  - FIX occupies T+33.
  - DONE is first seen at T+34, with div_ready_go=1 in that cycle.
  - Total latency is 34 cycles from div_valid to div_ready_go.
- With ms_allowin=1 in the first DONE cycle, the state is IDLE at T+35, and a back-to-back DIV is captured at T+35.
- With ms_allowin=0, DONE holds indefinitely with outputs stable.
- div_busy = (state != IDLE).
- Operands are read only at the capture edge. Later changes on div_src1, div_src2 or div_signed are ignored.
- div_valid dropping mid-operation without div_cancel is illegal; behaviour is unspecified, and a bench assertion checks for it.
- Reset asserted mid-ITER returns to the reset values immediately, with no clock required.

## Test plan
- DIVU 100 / 7 -> div_ready_go rises exactly 34 cycles after div_valid; quotient 14, remainder 2, div_by_zero 0.
- DIV −7 / 2 (0xFFFF_FFF9 / 2) -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. DIV 7 / −2 -> quotient 0xFFFF_FFFD, remainder 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0. DIVU same operands -> quotient 0, remainder 0x8000_0000.
- DIVU 5 / 0 -> quotient 0xFFFF_FFFF, remainder 5, div_by_zero 1. A following DIVU 9 / 3 clears the flag; quotient 3, remainder 0.
- Backpressure and cancel:
  - ms_allowin=0 for 3 DONE cycles -> outputs and div_ready_go=1 stable, then IDLE one cycle after ms_allowin=1.
  - div_cancel at ITER counter=10 -> IDLE next cycle, div_busy=0.
  - An immediately following DIVU 20 / 6 -> quotient 3, remainder 2 after 34 cycles.
- resetn pulsed low asynchronously mid-ITER -> all outputs at reset values before the next clk edge. The next DIVU 1 / 1 -> quotient 1, remainder 0.
